// File: rtl/matrix_mac_engine.sv
// matrix_mac_engine: NxN unsigned matrix multiply C = A x B,
// one multiply-accumulate per cycle with live read-back of C.
module matrix_mac_engine #(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int CW   = 18,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_mat,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic [IDXW-1:0] rd_idx,
  output logic [CW-1:0]   rd_data
);
  localparam int NN = N * N;
  localparam int DEPTH = 2 ** IDXW;
  localparam logic [IDXW-1:0] NW = IDXW'(N);
  localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);
  localparam logic [IDXW:0] NN_W = (IDXW + 1)'(NN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [DW-1:0]   a_mem [DEPTH];
  logic [DW-1:0]   b_mem [DEPTH];
  logic [CW-1:0]   c_mem [DEPTH];
  logic [CW-1:0]   acc;
  logic [IDXW-1:0] ci, cj, ck;
  logic [IDXW-1:0] a_idx, b_idx, c_idx;
  logic [2*DW-1:0] prod;
  logic [CW-1:0]   sum;
  logic            k_last, j_last, i_last;
  logic            wr_ok, rd_ok;

  assign a_idx = ci * NW + ck;
  assign b_idx = ck * NW + cj;
  assign c_idx = ci * NW + cj;

  assign k_last = (ck == LAST);
  assign j_last = (cj == LAST);
  assign i_last = (ci == LAST);

  assign prod = {{DW{1'b0}}, a_mem[a_idx]}
              * {{DW{1'b0}}, b_mem[b_idx]};
  // k = 0 starts a fresh dot product
  assign sum = ((ck == '0) ? '0 : acc) + CW'(prod);

  assign wr_ok = wr_en && (state_q == IDLE)
              && ({1'b0, wr_idx} < NN_W);
  assign rd_ok = ({1'b0, rd_idx} < NN_W);

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: if (k_last && j_last && i_last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ci      <= '0;
      cj      <= '0;
      ck      <= '0;
      acc     <= '0;
      err     <= 1'b0;
      rd_data <= '0;
      for (int x = 0; x < DEPTH; x++) begin
        a_mem[x] <= '0;
        b_mem[x] <= '0;
        c_mem[x] <= '0;
      end
    end else begin
      state_q <= state_d;
      err     <= wr_en && !wr_ok;
      rd_data <= rd_ok ? c_mem[rd_idx] : '0;
      if (wr_ok && !wr_mat) a_mem[wr_idx] <= wr_data;
      if (wr_ok && wr_mat) b_mem[wr_idx] <= wr_data;
      if (state_q == CALC) begin
        acc <= sum;
        if (k_last) c_mem[c_idx] <= sum;
        ck <= k_last ? '0 : ck + IDXW'(1);
        if (k_last)
          cj <= j_last ? '0 : cj + IDXW'(1);
        if (k_last && j_last)
          ci <= i_last ? '0 : ci + IDXW'(1);
      end
    end
  end
endmodule

// File: tb/tb_matrix_mac_engine.sv
// Randomized bench for matrix_mac_engine against a plain
// triple-loop matrix product model (N=3 and N=2 instances).
module tb_matrix_mac_engine;
  localparam int N = 3;
  localparam int DW = 8;
  localparam int CW = 18;
  localparam int IDXW = 4;
  localparam int NN = N * N;
  localparam int LAT = N * N * N;

  logic clk = 1'b0;
  logic rst;
  logic wr_en, wr_mat, start;
  logic [IDXW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] wr_data;
  logic busy, done, err;
  logic [CW-1:0] rd_data;

  logic u2_wr_en, u2_wr_mat, u2_start;
  logic [IDXW-1:0] u2_wr_idx, u2_rd_idx;
  logic [DW-1:0] u2_wr_data;
  logic u2_busy, u2_done, u2_err;
  logic [CW-1:0] u2_rd_data;

  int pass_cnt = 0;
  int total_cnt = 0;

  int unsigned ma [NN];
  int unsigned mb [NN];
  int unsigned mc [NN];
  int unsigned got_c [NN];

  int done_at, busy_cnt, err_cnt, err_at;
  bit busy_at_done, extra_done;

  always #5 clk = ~clk;

  matrix_mac_engine #(.N(N), .DW(DW), .CW(CW), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_mat(wr_mat),
    .wr_idx(wr_idx), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .err(err),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  matrix_mac_engine #(.N(2), .DW(DW), .CW(CW), .IDXW(IDXW)) dut2 (
    .clk(clk), .rst(rst),
    .wr_en(u2_wr_en), .wr_mat(u2_wr_mat),
    .wr_idx(u2_wr_idx), .wr_data(u2_wr_data),
    .start(u2_start), .busy(u2_busy), .done(u2_done),
    .err(u2_err),
    .rd_idx(u2_rd_idx), .rd_data(u2_rd_data)
  );

  function automatic void model_calc();
    int unsigned s;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += ma[i*N+k] * mb[k*N+j];
        mc[i*N+j] = s % (32'd1 << CW);
      end
  endfunction

  task automatic randomize_mats();
    for (int i = 0; i < NN; i++) begin
      ma[i] = $urandom_range(255, 0);
      mb[i] = $urandom_range(255, 0);
    end
  endtask

  task automatic load_mats();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NN; i++) begin
        @(negedge clk);
        wr_en = 1'b1;
        wr_mat = (m == 1);
        wr_idx = IDXW'(i);
        wr_data = DW'((m == 0) ? ma[i] : mb[i]);
      end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic read_all();
    @(negedge clk);
    rd_idx = '0;
    for (int i = 0; i < NN; i++) begin
      @(negedge clk);
      got_c[i] = rd_data;
      if (i < NN - 1) rd_idx = IDXW'(i + 1);
    end
  endtask

  task automatic run_calc(input int inj_wr, input int inj_st,
                          input int ws_idx, input int ws_data);
    done_at = -1;
    busy_cnt = 0;
    err_cnt = 0;
    err_at = -1;
    busy_at_done = 1'b0;
    extra_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    if (ws_idx >= 0) begin
      wr_en = 1'b1;
      wr_mat = 1'b0;
      wr_idx = IDXW'(ws_idx);
      wr_data = DW'(ws_data);
    end
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (err) begin
        err_cnt++;
        err_at = n;
      end
      if (done) begin
        done_at = n;
        busy_at_done = busy;
        break;
      end
      if (busy) busy_cnt++;
      wr_en = (n == inj_wr);
      wr_mat = 1'b0;
      wr_idx = '0;
      wr_data = 8'hAA;
      start = (n == inj_st);
      @(negedge clk);
    end
    wr_en = 1'b0;
    start = 1'b0;
    @(negedge clk);
    extra_done = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, err} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {busy, done, err});
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== '0)
      $display("FAIL reset_rd got %0d want 0", rd_data);
    else pass_cnt++;
    total_cnt++;
    if ({u2_busy, u2_done, u2_err} !== 3'b000)
      $display("FAIL reset_u2 got %b want 000",
               {u2_busy, u2_done, u2_err});
    else pass_cnt++;
    rst = 1'b0;
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== 0)
        $display("FAIL reset_c[%0d] got %0d want 0", i, got_c[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_fixed();
    int unsigned exp_c [NN] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    for (int i = 0; i < NN; i++) begin
      ma[i] = i + 1;
      mb[i] = 9 - i;
    end
    load_mats();
    model_calc();
    run_calc(-1, -1, -1, 0);
    total_cnt++;
    if (done_at !== LAT + 1)
      $display("FAIL fixed_done_at got %0d want %0d", done_at, LAT + 1);
    else pass_cnt++;
    total_cnt++;
    if (busy_cnt !== LAT)
      $display("FAIL fixed_busy_cycles got %0d want %0d", busy_cnt, LAT);
    else pass_cnt++;
    total_cnt++;
    if (busy_at_done !== 1'b0 || extra_done !== 1'b0)
      $display("FAIL fixed_done_pulse got busy=%b next_done=%b want 0 0",
               busy_at_done, extra_done);
    else pass_cnt++;
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== exp_c[i])
        $display("FAIL fixed_c[%0d] got %0d want %0d", i, got_c[i], exp_c[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < NN; i++) begin
      ma[i] = 255;
      mb[i] = 255;
    end
    load_mats();
    model_calc();
    run_calc(-1, -1, -1, 0);
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== 195075)
        $display("FAIL sat_c[%0d] got %0d want 195075", i, got_c[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      randomize_mats();
      load_mats();
      model_calc();
      run_calc(-1, -1, -1, 0);
      total_cnt++;
      if (done_at !== LAT + 1)
        $display("FAIL rand%0d_done_at got %0d want %0d",
                 it, done_at, LAT + 1);
      else pass_cnt++;
      read_all();
      for (int i = 0; i < NN; i++) begin
        total_cnt++;
        if (got_c[i] !== mc[i])
          $display("FAIL rand%0d_c[%0d] got %0d want %0d",
                   it, i, got_c[i], mc[i]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_busy_write();
    randomize_mats();
    load_mats();
    model_calc();
    run_calc(3, -1, -1, 0);
    total_cnt++;
    if (err_at !== 4 || err_cnt !== 1)
      $display("FAIL busy_wr_err got at=%0d cnt=%0d want at=4 cnt=1",
               err_at, err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (done_at !== LAT + 1)
      $display("FAIL busy_wr_done_at got %0d want %0d", done_at, LAT + 1);
    else pass_cnt++;
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== mc[i])
        $display("FAIL busy_wr_c[%0d] got %0d want %0d", i, got_c[i], mc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_write_start();
    int unsigned wv;
    wv = $urandom_range(255, 1);
    ma[4] = wv;
    model_calc();
    run_calc(-1, -1, 4, int'(wv));
    total_cnt++;
    if (err_cnt !== 0)
      $display("FAIL wr_start_err got %0d want 0", err_cnt);
    else pass_cnt++;
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== mc[i])
        $display("FAIL wr_start_c[%0d] got %0d want %0d", i, got_c[i], mc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    run_calc(-1, 10, -1, 0);
    total_cnt++;
    if (done_at !== LAT + 1)
      $display("FAIL b2b_first_done_at got %0d want %0d", done_at, LAT + 1);
    else pass_cnt++;
    run_calc(-1, -1, -1, 0);
    total_cnt++;
    if (done_at !== LAT + 1 || busy_cnt !== LAT)
      $display("FAIL b2b_second got done_at=%0d busy=%0d want %0d %0d",
               done_at, busy_cnt, LAT + 1, LAT);
    else pass_cnt++;
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== mc[i])
        $display("FAIL b2b_c[%0d] got %0d want %0d", i, got_c[i], mc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_bad_idx();
    @(negedge clk);
    wr_en = 1'b1;
    wr_mat = 1'b0;
    wr_idx = 4'd9;
    wr_data = 8'd77;
    @(negedge clk);
    total_cnt++;
    if (err !== 1'b1)
      $display("FAIL bad_idx9_err got %b want 1", err);
    else pass_cnt++;
    wr_mat = 1'b1;
    wr_idx = 4'd15;
    wr_data = 8'd99;
    @(negedge clk);
    total_cnt++;
    if (err !== 1'b1)
      $display("FAIL bad_idx15_err got %b want 1", err);
    else pass_cnt++;
    wr_en = 1'b0;
    rd_idx = 4'd12;
    @(negedge clk);
    total_cnt++;
    if (err !== 1'b0)
      $display("FAIL bad_idx_err_clear got %b want 0", err);
    else pass_cnt++;
    total_cnt++;
    if (rd_data !== '0)
      $display("FAIL rd_idx12 got %0d want 0", rd_data);
    else pass_cnt++;
    run_calc(-1, -1, -1, 0);
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== mc[i])
        $display("FAIL bad_idx_c[%0d] got %0d want %0d", i, got_c[i], mc[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_reset();
    int seen;
    randomize_mats();
    load_mats();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1)
      $display("FAIL mid_rst_busy_before got %b want 1", busy);
    else pass_cnt++;
    rst = 1'b1;
    wr_en = 1'b1;
    wr_mat = 1'b0;
    wr_idx = '0;
    wr_data = 8'd55;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b0;
    start = 1'b0;
    total_cnt++;
    if ({busy, done, err} !== 3'b000 || rd_data !== '0)
      $display("FAIL mid_rst_after got flags=%b rd=%0d want 000 0",
               {busy, done, err}, rd_data);
    else pass_cnt++;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    total_cnt++;
    if (seen !== 0)
      $display("FAIL mid_rst_no_done got %0d active cycles want 0", seen);
    else pass_cnt++;
    for (int i = 0; i < NN; i++) begin
      ma[i] = 0;
      mb[i] = 0;
      mc[i] = 0;
    end
    read_all();
    for (int i = 0; i < NN; i++) begin
      total_cnt++;
      if (got_c[i] !== 0)
        $display("FAIL mid_rst_c[%0d] got %0d want 0", i, got_c[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_n2();
    int unsigned exp2 [4] = '{5, 6, 7, 8};
    int d2;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        u2_wr_en = 1'b1;
        u2_wr_mat = (m == 1);
        u2_wr_idx = IDXW'(i);
        if (m == 0) u2_wr_data = (i == 0 || i == 3) ? 8'd1 : 8'd0;
        else u2_wr_data = DW'(5 + i);
      end
    @(negedge clk);
    u2_wr_en = 1'b0;
    u2_start = 1'b1;
    @(negedge clk);
    u2_start = 1'b0;
    d2 = -1;
    for (int n = 1; n <= 50; n++) begin
      if (u2_done) begin
        d2 = n;
        break;
      end
      @(negedge clk);
    end
    total_cnt++;
    if (d2 !== 9)
      $display("FAIL n2_done_at got %0d want 9", d2);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      u2_rd_idx = IDXW'(i);
      @(negedge clk);
      total_cnt++;
      if (u2_rd_data !== ((i < 4) ? CW'(exp2[i % 4]) : '0))
        $display("FAIL n2_c[%0d] got %0d want %0d", i, u2_rd_data,
                 (i < 4) ? exp2[i % 4] : 0);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_mat = 1'b0;
    wr_idx = '0;
    wr_data = '0;
    start = 1'b0;
    rd_idx = '0;
    u2_wr_en = 1'b0;
    u2_wr_mat = 1'b0;
    u2_wr_idx = '0;
    u2_wr_data = '0;
    u2_start = 1'b0;
    u2_rd_idx = '0;
    test_reset();
    test_fixed();
    test_saturate();
    test_random();
    test_busy_write();
    test_write_start();
    test_back_to_back();
    test_bad_idx();
    test_mid_reset();
    test_n2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/matrix_mac_engine.md
MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

Interface
REQ-001 SHALL have parameter N, default 3, meaning matrix dimension (NxN, N >= 2).
REQ-002 SHALL have parameter DW, default 8, meaning unsigned element width of A and B.
REQ-003 SHALL have parameter CW, default 18, meaning result element / accumulator width.
REQ-004 SHALL have parameter IDXW, default 4, meaning element index width (2^IDXW >= N*N).
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  meaning element write strobe.
REQ-008 SHALL have port wr_mat  input  1  meaning write target (0 = A, 1 = B).
REQ-009 SHALL have port wr_idx  input  IDXW  meaning row-major element index (row*N + col).
REQ-010 SHALL have port wr_data  input  DW  meaning element value.
REQ-011 SHALL have port start  input  1  meaning start the C = A x B computation.
REQ-012 SHALL have port busy  output  1  meaning computation in progress.
REQ-013 SHALL have port done  output  1  meaning one-cycle completion pulse.
REQ-014 SHALL have port err  output  1  meaning one-cycle pulse flagging a rejected write.
REQ-015 SHALL have port rd_idx  input  IDXW  meaning row-major C element select.
REQ-016 SHALL have port rd_data  output  CW  meaning registered C[rd_idx].

Function
REQ-017 SHALL implement states IDLE, CALC, DONE: IDLE->CALC on start; CALC->DONE after the last MAC; DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL, in IDLE, write wr_data into A or B[wr_idx] at the edge sampling wr_en when wr_idx < N*N.
REQ-019 SHALL drop a write and pulse err for one cycle when wr_idx >= N*N or when state is not IDLE.
REQ-020 SHALL, with wr_en and start sampled together in IDLE, commit the write so the computation uses the new value.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL perform one MAC per CALC cycle: loop order i (row), j (col), k (inner, fastest), acc += A[i][k]*B[k][j], with acc cleared at k = 0.
REQ-023 SHALL write C[i][j] at the edge completing k = N-1, leaving other C elements untouched.
REQ-024 SHALL hold busy high for exactly N^3 cycles, starting the cycle after start is sampled.
REQ-025 SHALL assert done for exactly one cycle, N^3 edges after the edge sampling start; busy is low in that cycle.
REQ-026 SHALL treat all arithmetic as unsigned: 2*DW-bit products, accumulation modulo 2^CW (exact when CW >= 2*DW + ceil(log2 N)).
REQ-027 SHALL register rd_data = C[rd_idx] with one-cycle latency; rd_data = 0 when rd_idx >= N*N.
REQ-028 SHALL keep reads live during CALC, returning current C contents including partially updated elements.
REQ-029 SHALL keep A, B, C unchanged across DONE and IDLE until explicitly overwritten or recomputed.

Reset
REQ-030 SHALL, when rst is sampled high, clear all A, B, C elements, acc and counters to 0, enter IDLE, and drive busy = 0, done = 0, err = 0, rd_data = 0 in the following cycle.
REQ-031 SHALL let rst override all other inputs, abort any CALC without asserting done, and ignore writes and start sampled in the same cycle as rst.

Verification
REQ-032 SHALL cover: N=3, A = 1..9, B = 9..1, start -> done 27 edges later; C = 30,24,18,84,69,54,138,114,90.
REQ-033 SHALL cover: all A, B elements = 255, N=3 -> every C element = 195075, with no wrap.
REQ-034 SHALL cover: wr_en during busy -> err pulses one cycle; final C identical to the result without that write.
REQ-035 SHALL cover: rst at the 10th CALC cycle -> busy 0 next cycle; done never asserts; rd_data = 0 for all indices.
REQ-036 SHALL cover: write at wr_idx = 9 (N=3) -> err pulse, A/B unchanged; rd_idx = 12 -> rd_data = 0.
REQ-037 SHALL cover: N=2, A = identity, B = 5,6,7,8 -> done 8 edges after start; C = 5,6,7,8.
